hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl_pkg.sv | 33 +++
 rtl/hazard_fwd_ctrl_fwd_src_sel.sv | 30 +++
 rtl/hazard_fwd_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-mux codes and the shadow
// scoreboard entry describing one in-flight instruction.
package hazard_fwd_ctrl_pkg;

  // Register index width held in a scoreboard entry; wide enough for any
  // REG_AW up to 8, narrower indices are zero-extended on entry.
  localparam int SB_RD_W = 8;

  typedef logic [SB_RD_W-1:0] sb_rd_t;
  typedef logic [1:0]         fwd_sel_t;

  // EX operand mux select codes
  localparam fwd_sel_t FWD_RF  = 2'b00;  // register file
  localparam fwd_sel_t FWD_WB  = 2'b01;  // writeback result
  localparam fwd_sel_t FWD_MEM = 2'b10;  // EX/MEM ALU result

  typedef struct packed {
    logic   valid;
    sb_rd_t rd;
    logic   regwrite;
    logic   memread;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: {SB_RD_W{1'b0}},
                                      regwrite: 1'b0, memread: 1'b0};

  // True when the entry holds a real instruction whose destination is the
  // given nonzero source register (x0 is never a dependency).
  function automatic logic rd_hit(input sb_entry_t e, input sb_rd_t src);
    return e.valid && (e.rd == src) && (src != {SB_RD_W{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_src_sel.sv
// Forwarding source selector for one ID operand: compares the source
// register against the EX and MEM scoreboard entries.
module fwd_src_sel
  import hazard_fwd_ctrl_pkg::*;
(
  input  sb_rd_t    src_i,
  input  logic      use_i,
  input  sb_entry_t ex_i,
  input  sb_entry_t mem_i,
  output fwd_sel_t  sel_o
);

  // A load in MEM is forwarded like any other write; only its valid/rd/
  // regwrite fields matter here.
  logic unused_mem_memread_s;
  assign unused_mem_memread_s = mem_i.memread;

  // Nearest producer wins; a load one ahead cannot forward (load-use stall).
  always_comb begin
    sel_o = FWD_RF;
    if (use_i && rd_hit(ex_i, src_i) && ex_i.regwrite && !ex_i.memread) begin
      sel_o = FWD_MEM;
    end else if (use_i && rd_hit(mem_i, src_i) && mem_i.regwrite) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
// Tracks EX/MEM destinations in a shadow scoreboard, registers operand
// forwarding selects for EX, stalls on load-use and flushes on taken branch.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              ex_branch_taken_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              pc_sel_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sb_entry_t        sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_t         sel_a_s, sel_b_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  sb_rd_t           rs1_s, rs2_s, rd_s;
  logic             lu_a_s, lu_b_s, load_use_s, branch_s, advance_s;

  assign rs1_s = sb_rd_t'(id_rs1_i);
  assign rs2_s = sb_rd_t'(id_rs2_i);
  assign rd_s  = sb_rd_t'(id_rd_i);

  fwd_src_sel u_fwd_a (
    .src_i (rs1_s),
    .use_i (id_use_rs1_i),
    .ex_i  (sb_ex_q),
    .mem_i (sb_mem_q),
    .sel_o (sel_a_s)
  );

  fwd_src_sel u_fwd_b (
    .src_i (rs2_s),
    .use_i (id_use_rs2_i),
    .ex_i  (sb_ex_q),
    .mem_i (sb_mem_q),
    .sel_o (sel_b_s)
  );

  // Load-use detection; a taken branch kills the consumer so it never stalls.
  always_comb begin
    branch_s   = ex_branch_taken_i;
    lu_a_s     = id_use_rs1_i && sb_ex_q.memread && rd_hit(sb_ex_q, rs1_s);
    lu_b_s     = id_use_rs2_i && sb_ex_q.memread && rd_hit(sb_ex_q, rs2_s);
    load_use_s = id_valid_i && (lu_a_s || lu_b_s) && !branch_s;
    advance_s  = id_valid_i && !load_use_s && !branch_s;
  end

  // Combinational pipeline control, held idle while reset is asserted.
  always_comb begin
    pc_sel_o     = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    if (rst_i) begin
      pc_sel_o     = branch_s;
      pc_write_o   = !load_use_s;
      ifid_write_o = !load_use_s;
      flush_ifid_o = branch_s;
      flush_idex_o = branch_s || load_use_s;
    end else begin
      pc_sel_o     = 1'b0;
      pc_write_o   = 1'b1;
      flush_idex_o = 1'b0;
    end
  end

  // Next state: scoreboard shift, EX forwarding selects, saturating counters.
  always_comb begin
    sb_mem_d    = sb_ex_q;
    sb_ex_d     = SB_BUBBLE;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (advance_s) begin
      sb_ex_d = '{valid: 1'b1, rd: rd_s, regwrite: id_regwrite_i,
                  memread: id_memread_i};
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end else begin
      sb_ex_d = SB_BUBBLE;
    end
    if (load_use_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (branch_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sb_ex_q     <= SB_BUBBLE;
      sb_mem_q    <= SB_BUBBLE;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard testbench for hazard_fwd_ctrl: a pipeline-level reference model
// predicts each cycle's outputs; a monitor pops and compares at negedge.
module tb_hazard_fwd_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_use_rs1_i, id_use_rs2_i;
  logic              id_regwrite_i, id_memread_i, ex_branch_taken_i;
  logic [1:0]        fwd_a_sel_o, fwd_b_sel_o;
  logic              pc_sel_o, pc_write_o, ifid_write_o;
  logic              flush_ifid_o, flush_idex_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_valid_i        (id_valid_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_use_rs1_i      (id_use_rs1_i),
    .id_use_rs2_i      (id_use_rs2_i),
    .id_rd_i           (id_rd_i),
    .id_regwrite_i     (id_regwrite_i),
    .id_memread_i      (id_memread_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .fwd_a_sel_o       (fwd_a_sel_o),
    .fwd_b_sel_o       (fwd_b_sel_o),
    .pc_sel_o          (pc_sel_o),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .flush_ifid_o      (flush_ifid_o),
    .flush_idex_o      (flush_idex_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction occupying a pipeline slot (bubble when v == 0)
  typedef struct { bit v; int rd; bit rw; bit mr; } slot_t;
  // Expected outputs for one cycle
  typedef struct { bit pcs, pcw, ifw, fif, fid; int fa, fb, sc, fc; } exp_t;

  slot_t pipe [2];           // [0] = instruction in EX, [1] = in MEM
  int    m_fa = 0, m_fb = 0, m_sc = 0, m_fc = 0;
  bit    last_lu = 1'b0;
  exp_t  q [$];
  int    total = 0, bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t bubble();
    slot_t s;
    s.v = 1'b0; s.rd = 0; s.rw = 1'b0; s.mr = 1'b0;
    return s;
  endfunction

  // Which stage will hold the value of src when the consumer reaches EX
  function automatic int fwd_of(input int src, input bit use_src);
    if (!use_src || src == 0) return 0;
    if (pipe[0].v && pipe[0].rw && !pipe[0].mr && pipe[0].rd == src) return 2;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == src) return 1;
    return 0;
  endfunction

  // Drive one cycle of inputs and push the predicted outputs for it
  task automatic issue(input bit rst, input bit v, input bit bt,
                       input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr);
    exp_t  e;
    slot_t s;
    bit    lu, adv;
    int    nfa, nfb;
    @(posedge clk_i);
    #1;
    rst_i = rst; id_valid_i = v; ex_branch_taken_i = bt;
    id_rs1_i = REG_AW'(rs1); id_rs2_i = REG_AW'(rs2);
    id_use_rs1_i = u1; id_use_rs2_i = u2;
    id_rd_i = REG_AW'(rd); id_regwrite_i = rw; id_memread_i = mr;
    e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
    lu = 1'b0;
    if (!rst) begin
      e.pcs = 1'b0; e.pcw = 1'b1; e.ifw = 1'b1; e.fif = 1'b0; e.fid = 1'b0;
      pipe[0] = bubble(); pipe[1] = bubble();
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    end else begin
      lu = v && !bt && pipe[0].v && pipe[0].mr &&
           ((u1 && rs1 != 0 && pipe[0].rd == rs1) ||
            (u2 && rs2 != 0 && pipe[0].rd == rs2));
      e.pcs = bt; e.pcw = !lu; e.ifw = !lu; e.fif = bt; e.fid = bt || lu;
      adv = v && !lu && !bt;
      nfa = adv ? fwd_of(rs1, u1) : 0;
      nfb = adv ? fwd_of(rs2, u2) : 0;
      if (lu && m_sc < CMAX) m_sc++;
      if (bt && m_fc < CMAX) m_fc++;
      s.v = 1'b1; s.rd = rd; s.rw = rw; s.mr = mr;
      pipe[1] = pipe[0];
      pipe[0] = adv ? s : bubble();
      m_fa = nfa; m_fb = nfb;
    end
    q.push_back(e);
    last_lu = lu;
  endtask

  task automatic op(input int rd, input int rs1, input int rs2, input bit mr);
    issue(1'b1, 1'b1, 1'b0, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, mr);
  endtask

  task automatic nop();
    issue(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the queued prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_sel",     int'(pc_sel_o),     int'(e.pcs));
        check("pc_write",   int'(pc_write_o),   int'(e.pcw));
        check("ifid_write", int'(ifid_write_o), int'(e.ifw));
        check("flush_ifid", int'(flush_ifid_o), int'(e.fif));
        check("flush_idex", int'(flush_idex_o), int'(e.fid));
        check("fwd_a",      int'(fwd_a_sel_o),  e.fa);
        check("fwd_b",      int'(fwd_b_sel_o),  e.fb);
        check("stall_cnt",  int'(stall_cnt_o),  e.sc);
        check("flush_cnt",  int'(flush_cnt_o),  e.fc);
      end
    end
  end

  // Stimulus: directed scenarios, counter saturation, then random traffic
  initial begin
    bit r_rst, r_v, r_bt, r_u1, r_u2, r_rw, r_mr;
    int r_rs1, r_rs2, r_rd;
    pipe[0] = bubble(); pipe[1] = bubble();
    rst_i = 1'b0; id_valid_i = 1'b0; ex_branch_taken_i = 1'b0;
    id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
    id_regwrite_i = 1'b0; id_memread_i = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    nop();
    #2 check("rst_fwd_a", int'(fwd_a_sel_o), 0);
    check("rst_stall_cnt", int'(stall_cnt_o), 0);

    // add x5 ; sub x6,x5 -> EX/MEM forward
    op(5, 1, 2, 1'b0); op(6, 5, 3, 1'b0); nop();
    #2 check("dist1_fwd_a", int'(fwd_a_sel_o), 2);
    // add x5 ; nop ; use x5 -> WB forward
    op(5, 1, 2, 1'b0); nop(); op(7, 5, 0, 1'b0); nop();
    #2 check("dist2_fwd_a", int'(fwd_a_sel_o), 1);
    // add x5 ; nop ; nop ; use x5 -> register file
    op(5, 1, 2, 1'b0); nop(); nop(); op(7, 5, 0, 1'b0); nop();
    #2 check("dist3_fwd_a", int'(fwd_a_sel_o), 0);

    // lw x7 ; add x8,x7,x7 -> one stall, then WB forward on both operands
    op(7, 1, 2, 1'b1); op(8, 7, 7, 1'b0);
    #2 check("lu_pc_write", int'(pc_write_o), 0);
    check("lu_ifid_write", int'(ifid_write_o), 0);
    check("lu_flush_idex", int'(flush_idex_o), 1);
    op(8, 7, 7, 1'b0);
    #2 check("lu_release_pc_write", int'(pc_write_o), 1);
    nop();
    #2 check("lu_fwd_a", int'(fwd_a_sel_o), 1);
    check("lu_fwd_b", int'(fwd_b_sel_o), 1);
    check("lu_stall_cnt", int'(stall_cnt_o), 1);

    // x0 is never a dependency, even for a load
    op(0, 1, 2, 1'b0); op(9, 0, 0, 1'b0); nop();
    #2 check("x0_fwd_a", int'(fwd_a_sel_o), 0);
    op(0, 1, 2, 1'b1); op(9, 0, 0, 1'b0);
    #2 check("x0_no_stall", int'(pc_write_o), 1);

    // taken branch coinciding with load-use -> flush, no stall
    op(7, 1, 2, 1'b1);
    issue(1'b1, 1'b1, 1'b1, 7, 7, 1'b1, 1'b1, 8, 1'b1, 1'b0);
    #2 check("br_pc_sel", int'(pc_sel_o), 1);
    check("br_flush_ifid", int'(flush_ifid_o), 1);
    check("br_flush_idex", int'(flush_idex_o), 1);
    check("br_pc_write", int'(pc_write_o), 1);
    nop();
    #2 check("br_flush_cnt", int'(flush_cnt_o), 1);
    check("br_stall_cnt", int'(stall_cnt_o), 1);

    // reset during a load-use stall
    op(7, 1, 2, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 7, 7, 1'b1, 1'b1, 8, 1'b1, 1'b0);
    #2 check("rst_mid_pc_write", int'(pc_write_o), 1);
    check("rst_mid_flush_idex", int'(flush_idex_o), 0);
    op(8, 7, 7, 1'b0);
    #2 check("post_rst_stall_cnt", int'(stall_cnt_o), 0);
    check("post_rst_flush_cnt", int'(flush_cnt_o), 0);
    check("post_rst_no_stall", int'(pc_write_o), 1);
    nop();
    #2 check("post_rst_fwd_a", int'(fwd_a_sel_o), 0);

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      op(3, 1, 2, 1'b1); op(4, 3, 0, 1'b0); op(4, 3, 0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    end
    nop();
    #2 check("sat_stall_cnt", int'(stall_cnt_o), CMAX);
    check("sat_flush_cnt", int'(flush_cnt_o), CMAX);

    // random traffic; a stalled instruction is re-presented unchanged
    issue(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    r_v = 1'b0; r_rs1 = 0; r_rs2 = 0; r_u1 = 1'b0; r_u2 = 1'b0;
    r_rd = 0; r_rw = 1'b0; r_mr = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!last_lu) begin
        r_v   = ($urandom_range(0, 7) != 0);
        r_rs1 = $urandom_range(0, 7);
        r_rs2 = $urandom_range(0, 7);
        r_u1  = ($urandom_range(0, 5) != 0);
        r_u2  = ($urandom_range(0, 5) != 0);
        r_rd  = $urandom_range(0, 7);
        r_rw  = ($urandom_range(0, 5) != 0);
        r_mr  = ($urandom_range(0, 2) == 0);
      end
      r_bt  = ($urandom_range(0, 7) == 0);
      r_rst = ($urandom_range(0, 99) != 0);
      issue(r_rst, r_v, r_bt, r_rs1, r_rs2, r_u1, r_u2, r_rd, r_rw, r_mr);
    end
    nop();
    repeat (3) @(negedge clk_i);
    check("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
